// File: rtl/csa_resolve_stream_if.sv
// Stream bundle for the carry-save resolve stage: carry-save beats in, binary words out.
// The master side drives beats and out_ready. The slave side is the resolve stage.
interface csa_resolve_stream_if #(
  parameter int W     = 25,
  parameter int IDX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_c;
  logic [W-1:0]     in_s;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_word;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             ovf;

  modport master (
    output in_valid, in_c, in_s, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_idx, out_last, ovf
  );

  modport slave (
    input  in_valid, in_c, in_s, in_last, out_ready,
    output in_ready, out_valid, out_word, out_idx, out_last, ovf
  );
endinterface

// File: rtl/csa_resolve_stream.sv
// Resolves a frame of carry-save word pairs (LSW first) into binary words.
// The inter-word carry is held in a register, and there is one output register.
module csa_resolve_stream #(
  parameter int W               = 25,
  parameter int IDX_W           = 8,
  parameter bit EMIT_CARRY_WORD = 1'b1
) (
  input logic clk,
  input logic rst_n,
  csa_resolve_stream_if.slave io
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [1:0]       carry_q, carry_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;

  logic             out_free;
  logic             in_ready;
  logic             accept;
  logic [W+1:0]     sum;

  assign out_free = !valid_q || io.out_ready;
  assign in_ready = (state_q == RUN) && out_free;
  assign accept   = io.in_valid && in_ready;

  // The carry vector carries weight 2^(i+1), so it enters the sum shifted left by one.
  assign sum = {2'b00, io.in_s} + {1'b0, io.in_c, 1'b0} + {{W{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = valid_q && !io.out_ready;
    word_d  = word_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          valid_d = 1'b1;
          word_d  = sum[W-1:0];
          idx_d   = cnt_q;
          if (io.in_last && !EMIT_CARRY_WORD) begin
            last_d  = 1'b1;
            carry_d = 2'd0;
            cnt_d   = '0;
          end else begin
            last_d  = 1'b0;
            carry_d = sum[W+1:W];
            // When the counter is at its maximum, the increment wraps to 0 and the overflow flag is set.
            cnt_d   = cnt_q + IDX_W'(1);
            if (&cnt_q) ovf_d = 1'b1;
            if (io.in_last) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // The carry word is emitted even when the carry is zero, so every frame has the same length.
        if (out_free) begin
          valid_d = 1'b1;
          word_d  = {{(W-2){1'b0}}, carry_q};
          idx_d   = cnt_q;
          last_d  = 1'b1;
          carry_d = 2'd0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      carry_q <= 2'd0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = valid_q;
  assign io.out_word  = word_q;
  assign io.out_idx   = idx_q;
  assign io.out_last  = last_q;
  assign io.ovf       = ovf_q;

endmodule
